// File: rtl/gate_pipe.sv
// gate_pipe: two-stage valid/ready pipeline that applies a bitwise gate
// operation to operands a and b, can OR the result into a sticky accumulator,
// and emits the result together with its population count.
//
// Ports
//   clk, reset          single clock, synchronous active-high reset
//   in_valid/in_ready   upstream handshake (in_ready is combinational)
//   a, b, op            operands and operation select
//                       (00 a&~b, 01 a&b, 10 a|b, 11 a^b)
//   acc_en, acc_clr     fold beat into accumulator / clear accumulator
//   out_valid/out_ready downstream handshake
//   z, ones             result and number of set bits in z
//   count               accepted input beats, wrapping
module gate_pipe #(
  parameter  int unsigned WIDTH = 8,
  parameter  int unsigned CNTW  = 16,
  localparam int unsigned ONESW = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  input  logic             acc_en,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] z,
  output logic [ONESW-1:0] ones,
  output logic [CNTW-1:0]  count
);

  // Pipeline and accumulator state
  logic             v1;
  logic             v2;
  logic [WIDTH-1:0] s1Data;
  logic [WIDTH-1:0] s2Data;
  logic [ONESW-1:0] s2Ones;
  logic [WIDTH-1:0] acc;
  logic [CNTW-1:0]  beatCount;

  // Combinational helpers
  logic             accept;
  logic             s1Move;
  logic             outXfer;
  logic [WIDTH-1:0] opResult;
  logic [WIDTH-1:0] accBase;
  logic [WIDTH-1:0] s1Next;
  logic [WIDTH-1:0] accNext;
  logic [ONESW-1:0] s1Ones;

  // Population count of a WIDTH-bit word
  function automatic logic [ONESW-1:0] popCount(input logic [WIDTH-1:0] v);
    logic [ONESW-1:0] n;
    n = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      n = n + ONESW'(v[i]);
    end
    return n;
  endfunction

  // Handshake decode; S1 drains into S2 whenever S2 is empty or emptying
  always_comb begin
    s1Move   = v1 && (!v2 || out_ready);
    in_ready = !v1 || s1Move;
    accept   = in_valid && in_ready;
    outXfer  = v2 && out_ready;
  end

  // Gate operation
  always_comb begin
    opResult = '0;
    unique case (op)
      2'b00:   opResult = a & ~b;
      2'b01:   opResult = a & b;
      2'b10:   opResult = a | b;
      2'b11:   opResult = a ^ b;
      default: opResult = '0;
    endcase
  end

  // Accumulator path: a coincident clear takes effect before the fold
  always_comb begin
    accBase = acc_clr ? '0 : acc;
    s1Next  = acc_en ? (accBase | opResult) : opResult;
    accNext = acc;
    if (accept && acc_en) begin
      accNext = accBase | opResult;
    end else if (acc_clr) begin
      accNext = '0;
    end
    s1Ones = popCount(s1Data);
  end

  // Stage 1 and accumulator
  always_ff @(posedge clk) begin
    if (reset) begin
      v1     <= 1'b0;
      s1Data <= '0;
      acc    <= '0;
    end else begin
      acc <= accNext;
      if (accept) begin
        v1     <= 1'b1;
        s1Data <= s1Next;
      end else if (s1Move) begin
        v1 <= 1'b0;
      end
    end
  end

  // Stage 2: result and its bit count register together
  always_ff @(posedge clk) begin
    if (reset) begin
      v2     <= 1'b0;
      s2Data <= '0;
      s2Ones <= '0;
    end else if (s1Move) begin
      v2     <= 1'b1;
      s2Data <= s1Data;
      s2Ones <= s1Ones;
    end else if (outXfer) begin
      v2 <= 1'b0;
    end
  end

  // Accepted-beat counter, wraps naturally
  always_ff @(posedge clk) begin
    if (reset) begin
      beatCount <= '0;
    end else if (accept) begin
      beatCount <= beatCount + CNTW'(1);
    end
  end

  assign out_valid = v2;
  assign z         = s2Data;
  assign ones      = s2Ones;
  assign count     = beatCount;

endmodule

// File: tb/tb_gate_pipe.sv
// Directed self-checking bench for gate_pipe (WIDTH=8, CNTW=16).
module tb_gate_pipe;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic [1:0] op;
  logic       acc_en;
  logic       acc_clr;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] z;
  logic [3:0] ones;
  logic [15:0] count;

  int nChecks = 0;
  int nPassed = 0;

  gate_pipe #(.WIDTH(8), .CNTW(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .acc_en    (acc_en),
    .acc_clr   (acc_clr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .z         (z),
    .ones      (ones),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got === exp) nPassed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Advance one clock and settle just after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; a = '0; b = '0; op = '0;
    acc_en = 1'b0; acc_clr = 1'b0; out_ready = 1'b1;

    // Reset state
    step(); step();
    reset = 1'b0;
    #1;
    checkVal("rst_out_valid", 32'(out_valid), 32'h0);
    checkVal("rst_z", 32'(z), 32'h00);
    checkVal("rst_ones", 32'(ones), 32'h0);
    checkVal("rst_count", 32'(count), 32'h0);
    checkVal("rst_in_ready", 32'(in_ready), 32'h1);

    // op=00 (a AND NOT b), back-to-back beats, two-stage latency
    in_valid = 1'b1; a = 8'hFF; b = 8'hFF; op = 2'b00;
    step();
    a = 8'hFF; b = 8'h00;
    step();
    in_valid = 1'b0;
    checkVal("andn1_valid", 32'(out_valid), 32'h1);
    checkVal("andn1_z", 32'(z), 32'h00);
    checkVal("andn1_ones", 32'(ones), 32'h0);
    step();
    checkVal("andn2_valid", 32'(out_valid), 32'h1);
    checkVal("andn2_z", 32'(z), 32'hFF);
    checkVal("andn2_ones", 32'(ones), 32'h8);
    step();
    checkVal("andn_drain", 32'(out_valid), 32'h0);
    checkVal("andn_count", 32'(count), 32'd2);

    // Back-pressure: only two beats held, order preserved
    out_ready = 1'b0; in_valid = 1'b1; op = 2'b10; b = 8'h00; a = 8'h01;
    #1 checkVal("bp_rdy0", 32'(in_ready), 32'h1);
    step();
    a = 8'h02;
    #1 checkVal("bp_rdy1", 32'(in_ready), 32'h1);
    step();
    a = 8'h03;
    #1 checkVal("bp_rdy2", 32'(in_ready), 32'h0);
    checkVal("bp_hold_valid", 32'(out_valid), 32'h1);
    checkVal("bp_hold_z1", 32'(z), 32'h01);
    step();
    checkVal("bp_rdy3", 32'(in_ready), 32'h0);
    checkVal("bp_hold_z2", 32'(z), 32'h01);
    out_ready = 1'b1;
    #1 checkVal("bp_rdy_release", 32'(in_ready), 32'h1);
    step();
    in_valid = 1'b0;
    checkVal("bp_z2", 32'(z), 32'h02);
    step();
    checkVal("bp_z3", 32'(z), 32'h03);
    step();
    checkVal("bp_drain", 32'(out_valid), 32'h0);
    checkVal("bp_count", 32'(count), 32'd5);

    // Accumulator: fold, clear-with-fold, clear without accept
    in_valid = 1'b1; op = 2'b10; b = 8'h00; acc_en = 1'b1; a = 8'h01;
    step();
    a = 8'h04;
    step();
    checkVal("acc_z01", 32'(z), 32'h01);
    a = 8'h80; acc_clr = 1'b1;
    step();
    checkVal("acc_z05", 32'(z), 32'h05);
    acc_clr = 1'b0; a = 8'h02;
    step();
    checkVal("acc_z80", 32'(z), 32'h80);
    checkVal("acc_ones80", 32'(ones), 32'h1);
    in_valid = 1'b0; acc_en = 1'b0; acc_clr = 1'b1;
    step();
    checkVal("acc_z82", 32'(z), 32'h82);
    checkVal("acc_ones82", 32'(ones), 32'h2);
    acc_clr = 1'b0; in_valid = 1'b1; acc_en = 1'b1; a = 8'h10;
    step();
    in_valid = 1'b0; acc_en = 1'b0;
    step();
    checkVal("acc_clr_alone_valid", 32'(out_valid), 32'h1);
    checkVal("acc_clr_alone_z", 32'(z), 32'h10);

    // op=01 AND and op=11 XOR
    in_valid = 1'b1; acc_en = 1'b0; a = 8'hF0; b = 8'h3C; op = 2'b01;
    step();
    op = 2'b11;
    step();
    in_valid = 1'b0;
    checkVal("and_z", 32'(z), 32'h30);
    checkVal("and_ones", 32'(ones), 32'h2);
    step();
    checkVal("xor_z", 32'(z), 32'hCC);
    checkVal("xor_ones", 32'(ones), 32'h4);
    step();
    checkVal("ops_drain", 32'(out_valid), 32'h0);
    checkVal("ops_count", 32'(count), 32'd12);

    // Counter wrap: stream beats until count passes 0xFFFF
    in_valid = 1'b1; a = 8'h00; b = 8'h00; op = 2'b00; out_ready = 1'b1;
    repeat (65535 - 12) step();
    checkVal("wrap_max", 32'(count), 32'hFFFF);
    checkVal("wrap_stream_valid", 32'(out_valid), 32'h1);
    step();
    checkVal("wrap_zero", 32'(count), 32'h0000);
    in_valid = 1'b0;
    step(); step();
    checkVal("wrap_drain", 32'(out_valid), 32'h0);

    // Reset with both stages full discards everything
    out_ready = 1'b0; in_valid = 1'b1; op = 2'b10; b = 8'h00; acc_en = 1'b1; a = 8'h55;
    step();
    a = 8'h20;
    step();
    checkVal("full_valid", 32'(out_valid), 32'h1);
    checkVal("full_rdy", 32'(in_ready), 32'h0);
    reset = 1'b1; out_ready = 1'b1; a = 8'h01;
    step();
    checkVal("mid_rst_valid", 32'(out_valid), 32'h0);
    checkVal("mid_rst_count", 32'(count), 32'h0);
    checkVal("mid_rst_z", 32'(z), 32'h00);
    checkVal("mid_rst_ones", 32'(ones), 32'h0);
    checkVal("mid_rst_rdy", 32'(in_ready), 32'h1);
    reset = 1'b0; in_valid = 1'b0; acc_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checkVal("post_rst_no_stale", 32'(out_valid), 32'h0);
    end
    in_valid = 1'b1; acc_en = 1'b1; op = 2'b10; b = 8'h00; a = 8'h02;
    step();
    in_valid = 1'b0; acc_en = 1'b0;
    step();
    checkVal("post_rst_valid", 32'(out_valid), 32'h1);
    checkVal("post_rst_acc_z", 32'(z), 32'h02);
    checkVal("post_rst_count", 32'(count), 32'd1);

    $display("%0d/%0d checks passed", nPassed, nChecks);
    $finish;
  end

endmodule

// File: doc/gate_pipe.md
GATE_PIPE -- requirements
Module: gate_pipe

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits (legal 1..32).
REQ-002 Parameter: CNTW, default 16, width of beat counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  upstream beat present.
REQ-006 in_ready  output  1  block can accept a beat this cycle.
REQ-007 a  input  WIDTH  operand A.
REQ-008 b  input  WIDTH  operand B.
REQ-009 op  input  2  operation select: 00 a AND NOT b, 01 a AND b, 10 a OR b, 11 a XOR b.
REQ-010 acc_en  input  1  fold this beat's result into the sticky accumulator.
REQ-011 acc_clr  input  1  clear the accumulator.
REQ-012 out_valid  output  1  result beat present.
REQ-013 out_ready  input  1  downstream accepts the result beat.
REQ-014 z  output  WIDTH  result.
REQ-015 ones  output  clog2(WIDTH+1)  number of 1 bits in z.
REQ-016 count  output  CNTW  number of accepted input beats.

Function
REQ-017 Accept a beat when in_valid && in_ready; transfer a result when out_valid && out_ready.
REQ-018 Two register stages S1, S2, each with a valid flag v1, v2; out_valid = v2; z and ones come from S2.
REQ-019 S2 loads from S1 when v1 && (!v2 || out_ready); v2 clears when a result transfers and S1 does not move.
REQ-020 in_ready = !v1 || (S1 moves to S2 this cycle); in_ready is combinational from out_ready and valid flags, never from in_valid.
REQ-021 Latency: result of an accepted beat appears on out_valid exactly 2 cycles after acceptance when not stalled; throughput one beat per cycle.
REQ-022 Under back-pressure, at most 2 beats are held; no beat is dropped, duplicated or reordered; z/ones stay stable while out_valid && !out_ready.
REQ-023 r = op result of a, b per REQ-009, bitwise over WIDTH.
REQ-024 On acceptance with acc_en=0: S1 captures r; accumulator unchanged.
REQ-025 On acceptance with acc_en=1: accumulator <= acc OR r and S1 captures acc OR r.
REQ-026 acc_clr (acts whether or not a beat is accepted) sets accumulator to 0; if coinciding with an accepted acc_en beat, clear applies first: accumulator <= r and S1 captures r.
REQ-027 ones computed from the S1 value when loading S2, registered with z.
REQ-028 count increments by 1 per accepted beat, wraps from 2^CNTW-1 to 0.
REQ-029 Inputs a, b, op, acc_en are don't-care when no beat is accepted.

Reset
REQ-030 While reset is high at a rising edge: v1=0, v2=0, accumulator=0, count=0, S1/S2 data=0; hence out_valid=0, z=0, ones=0, in_ready=1 the cycle after.
REQ-031 Reset mid-operation discards all in-flight beats without emitting them; reset overrides any simultaneous accept or transfer.

Verification
REQ-032 WIDTH=8: reset 2 cycles -> out_valid=0, z=0x00, count=0, in_ready=1.
REQ-033 a=0xFF, b=0xFF, op=00, out_ready=1 -> 2 cycles later out_valid=1, z=0x00, ones=0; then a=0xFF, b=0x00, op=00 -> z=0xFF, ones=8.
REQ-034 out_ready=0, offer beats op=10 with a=0x01,0x02,0x03 continuously -> two accepted, in_ready=0 thereafter; raise out_ready -> z sequence 0x01,0x02,0x03 in order, count=3.
REQ-035 acc_en=1 beats a=0x01 then a=0x04 (op=10, b=0) -> z=0x01 then 0x05; next beat a=0x80 with acc_en=1, acc_clr=1 -> z=0x80.
REQ-036 Accept 65536 beats with CNTW=16 -> count wraps to 0.
REQ-037 Reset asserted with v1=v2=1 -> next cycle out_valid=0, count=0, accumulator=0; no stale beat emitted after release.
